// File: rtl/game_pkg.sv
// Shared game definitions: state codes and status width, used by the flow
// controller and by display/snake logic.
package game_pkg;

    localparam int unsigned STATUS_W = 3;

    // State codes as they appear on game_status.
    typedef enum logic [STATUS_W-1:0] {
        ST_RESTART = 3'd0,
        ST_START   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_DIE     = 3'd3,
        ST_PAUSE   = 3'd4,
        ST_OVER    = 3'd5
    } game_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_flash_timer.sv
// Death flash timer: counts FLASH_HALF cycles per phase, inverts flash at the
// end of each phase and raises done on the edge of the final toggle.
// start is a level (high while the game is in DIE); clear wins over start.
module game_flash_timer
    import game_pkg::*;
#(
    parameter int unsigned FLASH_HALF    = 25_000_000,
    parameter int unsigned FLASH_TOGGLES = 6
) (
    input  logic clk,
    input  logic start,
    input  logic clear,
    output logic flash,
    output logic done
);

    localparam int unsigned CNT_W = cnt_width(FLASH_HALF);
    localparam int unsigned TOG_W = cnt_width(FLASH_TOGGLES);

    logic [CNT_W-1:0] cnt_q;
    logic [TOG_W-1:0] tog_q;
    logic             flash_q;
    logic             phase_end;

    assign phase_end = start && (cnt_q == CNT_W'(FLASH_HALF - 1));
    assign done      = phase_end && (tog_q == TOG_W'(FLASH_TOGGLES - 1));
    assign flash     = flash_q;

    // Phase counter, toggle counter and flash level.
    // NOTE: registered state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_q   <= '0;
            tog_q   <= '0;
            flash_q <= 1'b1;
        end else if (start) begin
            if (phase_end) begin
                cnt_q   <= '0;
                flash_q <= ~flash_q;
                tog_q   <= done ? '0 : tog_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: START -> PLAY -> DIE (flash) -> RESTART or OVER.
// Tracks lives, pulses life_lost on each death and drives an active-low
// restart pulse of RESTART_CYCLES cycles whenever RESTART is entered.
// Optional feature: define GAME_CTRL_PAUSE_EN to let pause_key toggle between
// PLAY and PAUSE; otherwise pause_key is ignored and PAUSE is unreachable.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned N_KEYS         = 4,
    parameter int unsigned FLASH_HALF     = 25_000_000,
    parameter int unsigned FLASH_TOGGLES  = 6,
    parameter int unsigned RESTART_CYCLES = 5,
    parameter int unsigned LIVES          = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_KEYS-1:0]          key_press,
    input  logic                       pause_key,
    input  logic                       hit_wall,
    input  logic                       hit_body,
    output logic [STATUS_W-1:0]        game_status,
    output logic                       die_flash,
    output logic                       restart,
    output logic [$clog2(LIVES+1)-1:0] lives_left,
    output logic                       life_lost
);

    localparam int unsigned LIVES_W = $clog2(LIVES + 1);
    localparam int unsigned RC_W    = cnt_width(RESTART_CYCLES);

    game_state_e      state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic             life_lost_q, life_lost_d;
    logic             restart_q, restart_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;

    logic key;
    logic collide;
    logic in_die;
    logic flash_done;

    assign key     = |key_press;
    assign collide = hit_wall | hit_body;
    assign in_die  = (state_q == ST_DIE);

`ifndef GAME_CTRL_PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause_key;
`endif

    // The timer is held clear everywhere except DIE, so no count survives an
    // abort by reset or a normal exit.
    game_flash_timer #(
        .FLASH_HALF   (FLASH_HALF),
        .FLASH_TOGGLES(FLASH_TOGGLES)
    ) u_timer (
        .clk  (clk),
        .start(in_die),
        .clear(rst || !in_die),
        .flash(die_flash),
        .done (flash_done)
    );

    // Next-state, lives, death pulse and restart-pulse sequencing.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        life_lost_d = 1'b0;
        restart_d   = 1'b1;
        rcnt_d      = '0;
        case (state_q)
            ST_START: begin
                if (key) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // A collision outranks a simultaneous pause request.
                if (collide) begin
                    state_d     = ST_DIE;
                    lives_d     = (lives_q == '0) ? '0 : lives_q - 1'b1;
                    life_lost_d = 1'b1;
                end
`ifdef GAME_CTRL_PAUSE_EN
                else if (pause_key) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
            ST_DIE: begin
                if (flash_done) begin
                    if (lives_q == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d   = ST_RESTART;
                        restart_d = 1'b0;
                    end
                end
            end
            ST_RESTART: begin
                // restart_q low means the pulse is still running; keys wait.
                if (!restart_q) begin
                    if (rcnt_q != RC_W'(RESTART_CYCLES - 1)) begin
                        restart_d = 1'b0;
                        rcnt_d    = rcnt_q + 1'b1;
                    end
                end else if (key) begin
                    state_d = ST_START;
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (pause_key) state_d = ST_PLAY;
            end
`endif
            ST_OVER: begin
                if (key) begin
                    state_d   = ST_RESTART;
                    lives_d   = LIVES_W'(LIVES);
                    restart_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_START;
            lives_q     <= LIVES_W'(LIVES);
            life_lost_q <= 1'b0;
            restart_q   <= 1'b1;
            rcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            life_lost_q <= life_lost_d;
            restart_q   <= restart_d;
            rcnt_q      <= rcnt_d;
        end
    end

    assign game_status = state_q;
    assign lives_left  = lives_q;
    assign life_lost   = life_lost_q;
    assign restart     = restart_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl (FLASH_HALF=4, FLASH_TOGGLES=6,
// RESTART_CYCLES=5, LIVES=2). Stimulus pushes each expected output change
// together with the number of cycles since the previous change; the monitor
// pops and compares whenever the sampled outputs change.
module tb_game_flow_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_press = '0;
    logic       pause_key = 1'b0;
    logic       hit_wall = 1'b0;
    logic       hit_body = 1'b0;
    logic [2:0] game_status;
    logic       die_flash;
    logic       restart;
    logic [1:0] lives_left;
    logic       life_lost;

    game_flow_ctrl #(
        .N_KEYS        (4),
        .FLASH_HALF    (4),
        .FLASH_TOGGLES (6),
        .RESTART_CYCLES(5),
        .LIVES         (2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .key_press  (key_press),
        .pause_key  (pause_key),
        .hit_wall   (hit_wall),
        .hit_body   (hit_body),
        .game_status(game_status),
        .die_flash  (die_flash),
        .restart    (restart),
        .lives_left (lives_left),
        .life_lost  (life_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       fl;
        logic       rs;
        logic [1:0] lv;
        logic       ll;
    } snap_t;

    typedef struct {
        snap_t s;
        int    dly;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic push(input game_state_e st, input logic fl, input logic rs,
                        input logic [1:0] lv, input logic ll, input int dly);
        exp_t e;
        e.s   = '{st: st, fl: fl, rs: rs, lv: lv, ll: ll};
        e.dly = dly;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Flash sequence after a death at edge D: life_lost drop, six toggles,
    // exit at D+24 to the given state with the given restart level.
    task automatic push_die_seq(input logic [1:0] lv, input game_state_e exit_st,
                                input logic exit_rs);
        push(ST_DIE, 1'b1, 1'b1, lv, 1'b0, 1);
        push(ST_DIE, 1'b0, 1'b1, lv, 1'b0, 3);
        push(ST_DIE, 1'b1, 1'b1, lv, 1'b0, 4);
        push(ST_DIE, 1'b0, 1'b1, lv, 1'b0, 4);
        push(ST_DIE, 1'b1, 1'b1, lv, 1'b0, 4);
        push(ST_DIE, 1'b0, 1'b1, lv, 1'b0, 4);
        push(exit_st, 1'b1, exit_rs, lv, 1'b0, 4);
    endtask

    // Monitor: compare on every change of the sampled outputs.
    initial begin
        snap_t prev;
        snap_t cur;
        exp_t  e;
        bit    have_prev;
        int    last;
        int    idx;
        have_prev = 1'b0;
        last      = 0;
        idx       = 0;
        forever begin
            @(negedge clk);
            cur = '{st: game_status, fl: die_flash, rs: restart, lv: lives_left, ll: life_lost};
            if (!have_prev || cur !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got st=%0d fl=%0b rs=%0b lv=%0d ll=%0b",
                             cyc, cur.st, cur.fl, cur.rs, cur.lv, cur.ll);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.s || (cyc - last) != e.dly) begin
                        errors++;
                        $display("FAIL step%0d cyc=%0d got st=%0d fl=%0b rs=%0b lv=%0d ll=%0b after %0d, want st=%0d fl=%0b rs=%0b lv=%0d ll=%0b after %0d",
                                 idx, cyc, cur.st, cur.fl, cur.rs, cur.lv, cur.ll, cyc - last,
                                 e.s.st, e.s.fl, e.s.rs, e.s.lv, e.s.ll, e.dly);
                    end
                end
                idx++;
                prev      = cur;
                have_prev = 1'b1;
                last      = cyc;
            end
        end
    end

    // Stimulus. Inputs change 1 time unit after a rising edge and are sampled
    // at the next one.
    initial begin
        // Reset state.
        push(ST_START, 1'b1, 1'b1, 2'd2, 1'b0, 1);
        tick(2); rst = 1'b0;

        // START -> PLAY one cycle after a key.
        push(ST_PLAY, 1'b1, 1'b1, 2'd2, 1'b0, 4);
        tick(2); key_press = 4'b0001;
        tick(1); key_press = '0;

        // First death: hit_wall, then keys and hit_body ignored in DIE.
        push(ST_DIE, 1'b1, 1'b1, 2'd1, 1'b1, 3);
        push_die_seq(2'd1, ST_RESTART, 1'b0);
        tick(2); hit_wall = 1'b1;
        tick(1); hit_wall = 1'b0;
        tick(1); key_press = 4'b1111; hit_body = 1'b1;
        tick(1); key_press = '0;      hit_body = 1'b0;

        // RESTART: pulse lasts 5 cycles, key in cycle 3 ignored, key in cycle 7 accepted.
        push(ST_RESTART, 1'b1, 1'b1, 2'd1, 1'b0, 5);
        push(ST_START,   1'b1, 1'b1, 2'd1, 1'b0, 2);
        tick(24); key_press = 4'b0100;
        tick(1);  key_press = '0;
        tick(3);  key_press = 4'b0010;
        tick(1);  key_press = '0;

        // Back to PLAY.
        push(ST_PLAY, 1'b1, 1'b1, 2'd1, 1'b0, 2);
        tick(1); key_press = 4'b1000;
        tick(1); key_press = '0;
        tick(1); pause_key = 1'b1;
        tick(1); pause_key = 1'b0;

`ifdef GAME_CTRL_PAUSE_EN
        // PAUSE ignores hits and keys; pause+wall together kills.
        push(ST_PAUSE, 1'b1, 1'b1, 2'd1, 1'b0, 2);
        push(ST_PLAY,  1'b1, 1'b1, 2'd1, 1'b0, 2);
        push(ST_DIE,   1'b1, 1'b1, 2'd0, 1'b1, 1);
        hit_body = 1'b1; key_press = 4'b0001;
        tick(1); hit_body = 1'b0; key_press = '0; pause_key = 1'b1;
        tick(1); hit_wall = 1'b1;
        tick(1); hit_wall = 1'b0; pause_key = 1'b0;
`else
        // pause_key ignored in PLAY; second death via hit_body.
        push(ST_DIE, 1'b1, 1'b1, 2'd0, 1'b1, 4);
        tick(1); hit_body = 1'b1;
        tick(1); hit_body = 1'b0;
`endif

        // Second death flashes out to OVER; key reloads lives into RESTART.
        push_die_seq(2'd0, ST_OVER, 1'b1);
        push(ST_RESTART, 1'b1, 1'b0, 2'd2, 1'b0, 4);
        push(ST_RESTART, 1'b1, 1'b1, 2'd2, 1'b0, 5);
        push(ST_START,   1'b1, 1'b1, 2'd2, 1'b0, 2);
        push(ST_PLAY,    1'b1, 1'b1, 2'd2, 1'b0, 2);
        tick(27); key_press = 4'b0001;
        tick(1);  key_press = '0;
        tick(6);  key_press = 4'b0001;
        tick(1);  key_press = '0;
        tick(1);  key_press = 4'b0001;
        tick(1);  key_press = '0;

        // Reset in DIE cycle 10 aborts the flash sequence.
        push(ST_DIE,   1'b1, 1'b1, 2'd1, 1'b1, 2);
        push(ST_DIE,   1'b1, 1'b1, 2'd1, 1'b0, 1);
        push(ST_DIE,   1'b0, 1'b1, 2'd1, 1'b0, 3);
        push(ST_DIE,   1'b1, 1'b1, 2'd1, 1'b0, 4);
        push(ST_START, 1'b1, 1'b1, 2'd2, 1'b0, 2);
        tick(1); hit_wall = 1'b1;
        tick(1); hit_wall = 1'b0;
        tick(9); rst = 1'b1;
        tick(1); rst = 1'b0;

        // Fresh death: first toggle again 4 cycles in, then reset while flash is 0.
        push(ST_PLAY,  1'b1, 1'b1, 2'd2, 1'b0, 2);
        push(ST_DIE,   1'b1, 1'b1, 2'd1, 1'b1, 2);
        push(ST_DIE,   1'b1, 1'b1, 2'd1, 1'b0, 1);
        push(ST_DIE,   1'b0, 1'b1, 2'd1, 1'b0, 3);
        push(ST_START, 1'b1, 1'b1, 2'd2, 1'b0, 2);
        tick(1); key_press = 4'b0010;
        tick(1); key_press = '0;
        tick(1); hit_wall = 1'b1;
        tick(1); hit_wall = 1'b0;
        tick(5); rst = 1'b1;
        tick(1); rst = 1'b0;

        tick(10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected changes never seen, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter N_KEYS, default 4, SHALL set the number of one-cycle key-press inputs.
REQ-003 Parameter FLASH_HALF, default 25_000_000, SHALL set the clock cycles per die_flash phase.
REQ-004 Parameter FLASH_TOGGLES, default 6, SHALL set the die_flash toggles per death; it SHALL be even and at least 2.
REQ-005 Parameter RESTART_CYCLES, default 5, SHALL set the width of the restart low pulse, in cycles.
REQ-006 Parameter LIVES, default 3, SHALL set the lives per game; it SHALL be at least 1.
REQ-007 Port clk, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1, SHALL be the synchronous active-high reset.
REQ-009 Port key_press, input, N_KEYS, SHALL carry one-cycle key pulses; any set bit counts as "key".
REQ-010 Port pause_key, input, 1, SHALL be a one-cycle pause-toggle pulse.
REQ-011 Ports hit_wall and hit_body, input, 1 each, SHALL flag collision in the current cycle.
REQ-012 Port game_status, output, 3, SHALL be the registered state code.
REQ-013 Port die_flash, output, 1, SHALL be the display-enable flash; 1 means visible.
REQ-014 Port restart, output, 1, SHALL be an active-low board-reinit pulse.
REQ-015 Port lives_left, output, $clog2(LIVES+1), SHALL hold the remaining lives.
REQ-016 Port life_lost, output, 1, SHALL be a one-cycle pulse on each death.

Function
REQ-017 State codes SHALL be: RESTART=0, START=1, PLAY=2, DIE=3, PAUSE=4, OVER=5; codes 6-7 SHALL recover to START on the next cycle.
REQ-018 In START, a key SHALL move the block to PLAY on the next cycle; otherwise it stays in START.
REQ-019 In PLAY, hit_wall|hit_body SHALL enter DIE next cycle, decrement lives_left (saturate at 0) and pulse life_lost for that cycle.
REQ-020 In PLAY, a collision SHALL take priority over a simultaneous pause_key.
REQ-021 In DIE, a cycle counter SHALL run from 0; at FLASH_HALF-1 die_flash inverts and the counter clears.
REQ-022 The first DIE toggle SHALL drive die_flash to 0; after FLASH_TOGGLES toggles die_flash is 1 and the block leaves DIE on the same edge.
REQ-023 DIE exit SHALL go to OVER if lives_left==0, else to RESTART; the counter SHALL clear on exit.
REQ-024 Collisions and keys SHALL be ignored in DIE.
REQ-025 On RESTART entry, restart SHALL be 0 for exactly RESTART_CYCLES cycles, then 1.
REQ-026 Keys in RESTART SHALL be ignored until the pulse completes; after that, a key SHALL move the block to START.
REQ-027 In OVER, die_flash SHALL be 1; a key SHALL reload lives_left to LIVES and enter RESTART.
REQ-028 Outside DIE, die_flash SHALL be 1; outside RESTART, restart SHALL be 1.

Reset
REQ-029 With rst=1 at a clock edge, outputs SHALL take: game_status=START, die_flash=1, restart=1, lives_left=LIVES, life_lost=0; the counter SHALL clear.
REQ-030 Reset mid-DIE or mid-RESTART SHALL abort the flash sequence or restart pulse with no residual count.

Configuration
REQ-031 With GAME_CTRL_PAUSE_EN defined, pause_key in PLAY SHALL enter PAUSE; in PAUSE, pause_key SHALL return to PLAY.
REQ-032 With GAME_CTRL_PAUSE_EN defined, collisions and keys SHALL be ignored in PAUSE.
REQ-033 With GAME_CTRL_PAUSE_EN undefined, pause_key SHALL be ignored and PAUSE SHALL be unreachable; the port is still present.

Structure
REQ-034 State codes and the status width SHALL live in shared package game_pkg, for use by display and snake logic.
REQ-035 Phase counting and toggle counting SHALL be a sub-module, game_flash_timer (inputs start and clear; outputs flash and done).

Verification (FLASH_HALF=4, FLASH_TOGGLES=6, RESTART_CYCLES=5, LIVES=2)
REQ-036 Reset, then key_press=4'b0001 -> game_status 1->2 one cycle after the key.
REQ-037 PLAY, hit_wall for one cycle -> status 3, life_lost one cycle, lives_left 1; die_flash 0 after 4 cycles, 6 toggles over 24 cycles, exit to RESTART with die_flash=1.
REQ-038 RESTART entry -> restart low for 5 cycles; key on cycle 3 ignored; key on cycle 7 -> START.
REQ-039 Second death -> lives_left 0, after flashing status 5; key -> lives_left 2 and status 0.
REQ-040 With GAME_CTRL_PAUSE_EN: pause_key -> PAUSE, hit_body ignored, pause_key -> PLAY; pause_key and hit_wall in the same cycle -> DIE.
REQ-041 rst asserted mid-DIE at cycle 10 -> next cycle status 1, die_flash 1, lives_left 2, counter 0.
